// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  // Number of pipeline stages needed to cover width bits with block-bit slices.
  function automatic int unsigned cla_stages(input int unsigned width, input int unsigned block);
    return (width + block - 1) / block;
  endfunction

  // Width of the most significant slice; equals block unless width is not a multiple of it.
  function automatic int unsigned cla_last_width(input int unsigned width, input int unsigned block);
    return width - (cla_stages(width, block) - 1) * block;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice with carry-out and carry into its top bit.
module cla_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] prop;
  logic [BLOCK-1:0] gen;
  logic [BLOCK:0]   carry;
  logic             term;
  logic             chain;

  assign prop = a ^ b;
  assign gen  = a & b;

  // Each carry is a flat sum of generate terms gated by the propagate chain below them.
  always_comb begin
    carry    = '0;
    term     = 1'b0;
    chain    = 1'b0;
    carry[0] = cin;
    for (int i = 0; i < int'(BLOCK); i++) begin
      term  = gen[i];
      chain = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        term  = term | (chain & gen[j]);
        chain = chain & prop[j];
      end
      carry[i+1] = term | (chain & cin);
    end
  end

  assign sum   = prop ^ carry[BLOCK-1:0];
  assign cout  = carry[BLOCK];
  assign c_msb = carry[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CLA slice per stage, carry registered between stages,
// valid/ready handshake with a single global advance signal.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BLOCK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int unsigned STAGES = cla_stages(WIDTH, BLOCK);
  localparam int unsigned LAST_W = cla_last_width(WIDTH, BLOCK);

  // Operands ride along with the partial sum; b is already inverted for subtraction.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  logic   advance;

  assign advance = ~stage_q[STAGES-1].valid | i_ready;
  assign o_ready = advance;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned LO = k * BLOCK;
    localparam int unsigned SW = (k == int'(STAGES) - 1) ? LAST_W : BLOCK;

    stage_t         prev;
    stage_t         nxt;
    logic [SW-1:0]  slice_sum;
    logic           slice_cout;
    logic           slice_cmsb;

    if (k == 0) begin : g_first
      always_comb begin
        prev       = '0;
        prev.valid = i_valid;
        prev.a     = i_add1;
        prev.b     = i_sub ? ~i_add2 : i_add2;
        prev.carry = i_sub | i_cin;
      end
    end else begin : g_next
      assign prev = stage_q[k-1];
    end

    // The top slice is only as wide as the remaining bits, so its carry-out is the carry out of bit WIDTH-1.
    cla_block #(.BLOCK(SW)) u_cla (
      .a     (prev.a[LO +: SW]),
      .b     (prev.b[LO +: SW]),
      .cin   (prev.carry),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_cmsb)
    );

    always_comb begin
      nxt               = prev;
      nxt.sum[LO +: SW] = slice_sum;
      nxt.carry         = slice_cout;
      nxt.ovf           = slice_cout ^ slice_cmsb;
    end

    assign stage_d[k] = nxt;
  end

  // Whole pipeline shifts together; a stall freezes every stage including the output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(STAGES); k++) stage_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < int'(STAGES); k++) stage_q[k] <= stage_d[k];
    end
  end

  assign o_valid    = stage_q[STAGES-1].valid;
  assign o_result   = {stage_q[STAGES-1].carry, stage_q[STAGES-1].sum};
  assign o_overflow = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder in three geometries: 8/4, 10/4 and 3/1.
module tb_pipelined_cla_adder;

  typedef struct {
    logic [10:0] res;
    logic        ovf;
    int          t;
    bit          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  logic        iv   [3];
  logic        ir   [3];
  logic        cin  [3];
  logic        sub  [3];
  logic [9:0]  a    [3];
  logic [9:0]  b    [3];
  logic        rdy  [3];
  logic        ov   [3];
  logic        ofl  [3];
  logic [10:0] res  [3];

  logic [8:0]  res8;
  logic [10:0] res10;
  logic [3:0]  res3;

  exp_t q [3][$];

  assign res[0] = 11'(res8);
  assign res[1] = 11'(res10);
  assign res[2] = 11'(res3);

  pipelined_cla_adder #(.WIDTH(8), .BLOCK(4)) u_p8 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[0]), .o_ready(rdy[0]),
    .i_add1(a[0][7:0]), .i_add2(b[0][7:0]), .i_cin(cin[0]), .i_sub(sub[0]),
    .o_valid(ov[0]), .i_ready(ir[0]), .o_result(res8), .o_overflow(ofl[0])
  );

  pipelined_cla_adder #(.WIDTH(10), .BLOCK(4)) u_p10 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[1]), .o_ready(rdy[1]),
    .i_add1(a[1]), .i_add2(b[1]), .i_cin(cin[1]), .i_sub(sub[1]),
    .o_valid(ov[1]), .i_ready(ir[1]), .o_result(res10), .o_overflow(ofl[1])
  );

  pipelined_cla_adder #(.WIDTH(3), .BLOCK(1)) u_p3 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[2]), .o_ready(rdy[2]),
    .i_add1(a[2][2:0]), .i_add2(b[2][2:0]), .i_cin(cin[2]), .i_sub(sub[2]),
    .o_valid(ov[2]), .i_ready(ir[2]), .o_result(res3), .o_overflow(ofl[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on WIDTH+1 bits, signed overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [9:0] av, input logic [9:0] bv,
                                 input logic c, input logic s);
    exp_t        e;
    logic [10:0] mask;
    logic [10:0] bb;
    logic [10:0] full;
    mask  = 11'((1 << w) - 1);
    bb    = s ? (~{1'b0, bv} & mask) : ({1'b0, bv} & mask);
    full  = {1'b0, av} + bb + (s ? 11'd1 : 11'(c));
    e.res = full & ((mask << 1) | 11'd1);
    e.ovf = (av[w-1] == bb[w-1]) && (full[w-1] != av[w-1]);
    e.t   = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : 3;
  endfunction

  task automatic send(input int k, input logic [9:0] av, input logic [9:0] bv, input logic c,
                      input logic s, input logic [10:0] er, input logic eo, input bit lat);
    exp_t e;
    bit   ok;
    a[k] = av; b[k] = bv; cin[k] = c; sub[k] = s; iv[k] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rdy[k]) begin
        e.res = er; e.ovf = eo; e.t = cyc; e.lat = lat;
        q[k].push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout[%0d]: o_ready stayed 0 required 1", k);
    end
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int n = 0; n < 300 && q[k].size() != 0; n++) @(posedge clk);
    if (q[k].size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout[%0d]: %0d results missing required 0", k, q[k].size());
    end
    @(posedge clk); #1;
  endtask

  // Monitors: compare the head of the scoreboard every cycle an output is presented.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      if (!rst && ov[g]) begin
        if (q[g].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out[%0d]: got result %0h required no output", g, res[g]);
        end else begin
          check($sformatf("result[%0d]", g), 32'(res[g]), 32'(q[g][0].res));
          check($sformatf("overflow[%0d]", g), 32'(ofl[g]), 32'(q[g][0].ovf));
          if (q[g][0].lat) begin
            check($sformatf("latency[%0d]", g), 32'(cyc - q[g][0].t), 32'(lat_of(g)));
            q[g][0].lat = 1'b0;
          end
          if (!ir[g]) check($sformatf("ready_stalled[%0d]", g), 32'(rdy[g]), 32'd0);
          else void'(q[g].pop_front());
        end
      end
    end
  end

  logic [9:0] va [6];
  logic [9:0] vb [6];
  logic       vc [6];
  logic       vs [6];
  exp_t       ee;
  bit         done;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ir[k] = 1'b1; cin[k] = 1'b0; sub[k] = 1'b0; a[k] = '0; b[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid[%0d]", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_result[%0d]", k), 32'(res[k]), 32'd0);
      check($sformatf("rst_ovf[%0d]", k), 32'(ofl[k]), 32'd0);
    end
    rst = 1'b0;

    // Reset while items are in flight and i_valid is still high.
    @(posedge clk); #1;
    a[0] = 10'h012; b[0] = 10'h034; iv[0] = 1'b1;
    @(posedge clk); #1;
    a[0] = 10'h056;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(ov[0]), 32'd0);
    check("midrst_result", 32'(res[0]), 32'd0);
    iv[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_valid", 32'(ov[0]), 32'd0);

    // Directed add/sub on 8/4 with an idle pipe so latency is checked.
    send(0, 10'h0FF, 10'h001, 1'b0, 1'b0, 11'h100, 1'b0, 1'b1); drain(0);
    send(0, 10'h07F, 10'h001, 1'b0, 1'b0, 11'h080, 1'b1, 1'b1); drain(0);
    send(0, 10'h005, 10'h007, 1'b0, 1'b1, 11'h0FE, 1'b0, 1'b1); drain(0);
    send(0, 10'h080, 10'h001, 1'b1, 1'b1, 11'h17F, 1'b1, 1'b1); drain(0);
    send(0, 10'h0A5, 10'h05A, 1'b1, 1'b0, 11'h100, 1'b0, 1'b1); drain(0);

    // Six back-to-back ops with a three-cycle downstream stall.
    va = '{10'h03C, 10'h0C8, 10'h07F, 10'h000, 10'h0F0, 10'h064};
    vb = '{10'h0A1, 10'h037, 10'h07F, 10'h001, 10'h00F, 10'h0C8};
    vc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ee = model(8, va[i], vb[i], vc[i], vs[i]);
          send(0, va[i], vb[i], vc[i], vs[i], ee.res, ee.ovf, 1'b0);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 ir[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 ir[0] = 1'b1;
      end
    join
    drain(0);

    // Odd geometry 10/4: three stages, short top slice.
    send(1, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 11'h7FF, 1'b0, 1'b1); drain(1);
    send(1, 10'h200, 10'h001, 1'b0, 1'b1, 11'h5FF, 1'b1, 1'b1); drain(1);
    send(1, 10'h155, 10'h0AA, 1'b0, 1'b0, 11'h1FF, 1'b0, 1'b1); drain(1);

    // Exhaustive 3/1 with random input gaps and random downstream ready.
    fork
      begin
        while (!done) begin
          @(posedge clk); #1;
          ir[2] = 1'($urandom_range(0, 1));
        end
        ir[2] = 1'b1;
      end
      begin
        for (int av = 0; av < 8; av++)
          for (int bv = 0; bv < 8; bv++)
            for (int s = 0; s < 2; s++)
              for (int c = 0; c < 2; c++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                ee = model(3, 10'(av), 10'(bv), 1'(c), 1'(s));
                send(2, 10'(av), 10'(bv), 1'(c), 1'(s), ee.res, ee.ovf, 1'b0);
              end
        done = 1'b1;
      end
    join
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t required finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
